// File: rtl/fifo_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arb_pkg
// Brief    : Shared types, constants and helpers for the FIFO read arbiter.
// Revision : 1.0
// ============================================================================
package fifo_rd_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int STARVE_LIMIT = 64;

   // Width helper that never returns zero, so 1-entry ranges still get a bit.
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; scans upward from last_win+1.
// Revision : 1.0
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_win,
   output logic [NUM_REQ-1:0] gnt_nxt,
   output logic [ID_W-1:0]    id_nxt,
   output logic               any
);

   logic            w_found;
   logic [ID_W-1:0] w_idx;

   always_comb begin
      gnt_nxt = '0;
      id_nxt  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_W'((int'(last_win) + k) % NUM_REQ);
         if (!w_found && req[w_idx]) begin
            w_found        = 1'b1;
            gnt_nxt[w_idx] = 1'b1;
            id_nxt         = w_idx;
         end
      end
   end

   assign any = |req;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Brief    : Round-robin, burst-bounded sharing of an async FIFO read port.
//            Optional statistics outputs enabled by FIFO_RD_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int BURST_MAX  = 4,
   localparam int ID_W       = clog2_safe(NUM_REQ),
   localparam int CNT_W      = clog2_safe(BURST_MAX + 1)
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  fifo_rempty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rd_en,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ID_W-1:0]       out_id,
   output logic                  busy
`ifdef FIFO_RD_ARB_STATS_EN
   ,
   output logic [15:0]           pop_count,
   output logic [NUM_REQ-1:0]    starve_flag
`endif
);

   localparam logic [0:0] c_ST_IDLE  = ST_IDLE;
   localparam logic [0:0] c_ST_BURST = ST_BURST;

   logic [0:0]         r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [ID_W-1:0]    r_win_id;
   logic [ID_W-1:0]    r_last_win;
   logic [CNT_W-1:0]   r_burst_cnt;
   logic               r_out_valid;
   logic [ID_W-1:0]    r_out_id;

   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic [ID_W-1:0]    w_id_nxt;
   logic               w_any;
   logic               w_in_burst;
   logic               w_req_win;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_exit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req      (req),
      .last_win (r_last_win),
      .gnt_nxt  (w_gnt_nxt),
      .id_nxt   (w_id_nxt),
      .any      (w_any)
   );

   // The pop is gated by the live empty flag so the FIFO can never underflow.
   always_comb begin
      w_in_burst = (r_state == c_ST_BURST);
      w_req_win  = req[r_win_id];
      fifo_rd_en = w_in_burst & w_req_win & ~fifo_rempty;
      w_cnt_inc  = r_burst_cnt + CNT_W'(1);
      w_exit     = w_in_burst &
                   ((fifo_rd_en & (w_cnt_inc == CNT_W'(BURST_MAX))) | ~w_req_win | fifo_rempty);
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_state     <= c_ST_IDLE;
         r_gnt       <= '0;
         r_win_id    <= '0;
         r_last_win  <= ID_W'(NUM_REQ - 1);
         r_burst_cnt <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
      end else begin
         r_out_valid <= fifo_rd_en;
         r_out_id    <= r_win_id;
         if (r_state == c_ST_IDLE) begin
            if (w_any && !fifo_rempty) begin
               r_state     <= c_ST_BURST;
               r_gnt       <= w_gnt_nxt;
               r_win_id    <= w_id_nxt;
               r_burst_cnt <= '0;
            end
         end else begin
            if (fifo_rd_en) begin
               r_burst_cnt <= w_cnt_inc;
            end
            if (w_exit) begin
               r_state    <= c_ST_IDLE;
               r_last_win <= r_win_id;
               r_gnt      <= '0;
            end
         end
      end
   end

   assign gnt       = r_gnt;
   assign busy      = w_in_burst;
   assign out_valid = r_out_valid;
   assign out_id    = r_out_id;
   assign out_data  = fifo_rdata;

`ifdef FIFO_RD_ARB_STATS_EN
   localparam int c_WAIT_W = clog2_safe(STARVE_LIMIT + 1);

   logic [15:0] r_pop_count;

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_pop_count <= '0;
      end else if (fifo_rd_en && (r_pop_count != 16'hFFFF)) begin
         r_pop_count <= r_pop_count + 16'd1;
      end
   end

   assign pop_count = r_pop_count;

   // Wait time only accrues while the FIFO has data; an empty FIFO is not starvation.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
      logic [c_WAIT_W-1:0] r_wait;
      logic                r_flag;

      always_ff @(posedge rd_clk) begin
         if (rd_rst) begin
            r_wait <= '0;
            r_flag <= 1'b0;
         end else if (!req[gi] || r_gnt[gi]) begin
            r_wait <= '0;
         end else if (!fifo_rempty) begin
            if (r_wait == c_WAIT_W'(STARVE_LIMIT)) begin
               r_flag <= 1'b1;
            end else begin
               r_wait <= r_wait + c_WAIT_W'(1);
            end
         end
      end

      assign starve_flag[gi] = r_flag;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Brief    : Self-checking bench for fifo_rd_arbiter with a FIFO and arbiter model.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BM = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic [N-1:0]  req;
   logic          fifo_rempty;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_rd_en;
   logic [N-1:0]  gnt;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_id;
   logic          busy;
`ifdef FIFO_RD_ARB_STATS_EN
   logic [15:0]   pop_count;
   logic [N-1:0]  starve_flag;
`endif

   always #5 rd_clk = ~rd_clk;

   fifo_rd_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .BURST_MAX  (BM)
   ) dut (
      .rd_clk      (rd_clk),
      .rd_rst      (rd_rst),
      .req         (req),
      .fifo_rempty (fifo_rempty),
      .fifo_rdata  (fifo_rdata),
      .fifo_rd_en  (fifo_rd_en),
      .gnt         (gnt),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_id      (out_id),
      .busy        (busy)
`ifdef FIFO_RD_ARB_STATS_EN
      ,
      .pop_count   (pop_count),
      .starve_flag (starve_flag)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   // FIFO contents and reference state: owner is the granted requester or -1.
   logic [DW-1:0] fifo_q[$];
   int            m_owner = -1;
   int            m_pops  = 0;
   int            m_last  = N - 1;
   int            m_oid   = 0;
   bit            m_ov    = 1'b0;
   logic [DW-1:0] m_odata = '0;
   int            m_popcnt = 0;
   int            m_wait[N];
   bit [N-1:0]    m_starve = '0;
   logic [N-1:0]  exp_gnt;
   bit            exp_busy;
   bit            exp_rd_en;

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic observe();
      @(negedge rd_clk);
      exp_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      exp_busy  = (m_owner >= 0);
      exp_rd_en = (m_owner >= 0) && req[m_owner] && !fifo_rempty;
   endtask

   task automatic advance();
      bit pop;
      int nxt;
      @(posedge rd_clk);
      pop = exp_rd_en;
      if (rd_rst) m_popcnt = 0;
      else if (pop && m_popcnt < 65535) m_popcnt++;
      for (int i = 0; i < N; i++) begin
         if (rd_rst) begin
            m_wait[i] = 0; m_starve[i] = 1'b0;
         end else if (!req[i] || m_owner == i) begin
            m_wait[i] = 0;
         end else if (!fifo_rempty) begin
            m_wait[i]++;
            if (m_wait[i] > 64) m_starve[i] = 1'b1;
         end
      end
      if (rd_rst) begin
         m_owner = -1; m_pops = 0; m_last = N - 1; m_ov = 1'b0; m_oid = 0;
      end else begin
         m_ov = pop;
         if (pop) m_oid = m_owner;
         if (m_owner >= 0) begin
            if (pop) m_pops++;
            if ((pop && m_pops == BM) || !req[m_owner] || fifo_rempty) begin
               m_last  = m_owner;
               m_owner = -1;
            end
         end else if (req != '0 && !fifo_rempty) begin
            nxt     = pick(req, m_last);
            m_owner = nxt;
            m_pops  = 0;
         end
      end
      #1;
      if (pop) begin
         fifo_rdata = fifo_q.pop_front();
         m_odata    = fifo_rdata;
      end
      fifo_rempty = (fifo_q.size() == 0);
   endtask

   task automatic fill(input int n);
      repeat (n) fifo_q.push_back(DW'($urandom));
      fifo_rempty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      rd_rst = 1'b1;
      req    = '0;
      fifo_q.delete();
      fifo_rempty = 1'b1;
      repeat (2) begin observe(); advance(); end
      rd_rst = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst = 1'b1;
      req    = 4'b1111;
      fill(5);
      observe(); advance();
      observe();
      vectors++;
      if ({gnt, busy, fifo_rd_en, out_valid, out_id} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_state: got gnt=%b busy=%b rd_en=%b ov=%b id=%0d want all zero",
                  gnt, busy, fifo_rd_en, out_valid, out_id);
      end
`ifdef FIFO_RD_ARB_STATS_EN
      vectors++;
      if (pop_count !== 16'd0 || starve_flag !== '0) begin
         miscompares++;
         $display("FAIL reset_stats: got pop_count=%0d starve=%b want 0/0", pop_count, starve_flag);
      end
`endif
      advance();
      rd_rst = 1'b0;
   endtask

   task automatic test_single_req();
      do_reset();
      fill(10);
      req = 4'b0001;
      for (int c = 0; c < 12; c++) begin
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL single_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (m_ov) begin
            vectors++;
            if ({out_id, out_data} !== {2'(m_oid), m_odata}) begin
               miscompares++;
               $display("FAIL single_data c=%0d: got id=%0d data=%h want id=%0d data=%h",
                        c, out_id, out_data, m_oid, m_odata);
            end
         end
         if (c == 1 || c == 5) begin
            vectors++;
            if (gnt !== ((c == 1) ? 4'b0001 : 4'b0000)) begin
               miscompares++;
               $display("FAIL single_grant c=%0d: got %b", c, gnt);
            end
         end
         advance();
      end
   endtask

   task automatic test_all_req();
      logic [1:0] ids[$];
      do_reset();
      fill(32);
      req = 4'b1111;
      for (int c = 0; c < 22; c++) begin
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL all_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (m_ov) begin
            vectors++;
            if (out_data !== m_odata) begin
               miscompares++;
               $display("FAIL all_data c=%0d: got %h want %h", c, out_data, m_odata);
            end
         end
         if (out_valid === 1'b1) ids.push_back(out_id);
         advance();
      end
      for (int j = 0; j < 16; j++) begin
         vectors++;
         if (j >= ids.size() || ids[j] !== 2'(j / 4)) begin
            miscompares++;
            $display("FAIL all_id_seq j=%0d: got %0d want %0d", j,
                     (j < ids.size()) ? int'(ids[j]) : -1, j / 4);
         end
      end
   endtask

   task automatic test_empty_mid_burst();
      int pops = 0;
      do_reset();
      fill(2);
      req = 4'b0100;
      for (int c = 0; c < 8; c++) begin
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL empty_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (fifo_rd_en === 1'b1) pops++;
         advance();
      end
      vectors++;
      if (pops != 2) begin
         miscompares++;
         $display("FAIL empty_pops: got %0d want 2", pops);
      end
   endtask

   task automatic test_req_drop();
      do_reset();
      fill(20);
      req = 4'b1110;
      for (int c = 0; c < 9; c++) begin
         if (c == 3) req = 4'b1100;
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL drop_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (c == 5) begin
            vectors++;
            if (gnt !== 4'b0100) begin
               miscompares++;
               $display("FAIL drop_next_grant: got %b want 0100", gnt);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      fill(10);
      req = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         rd_rst = (c == 2);
         if (c == 3) req = 4'b1111;
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL rstmid_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (c == 3) begin
            vectors++;
            if ({gnt, out_valid, busy} !== 6'b0) begin
               miscompares++;
               $display("FAIL rstmid_after: got gnt=%b ov=%b busy=%b want 0", gnt, out_valid, busy);
            end
         end
         if (c == 4) begin
            vectors++;
            if (gnt !== 4'b0001) begin
               miscompares++;
               $display("FAIL rstmid_priority: got %b want 0001", gnt);
            end
         end
         advance();
      end
      rd_rst = 1'b0;
   endtask

`ifdef FIFO_RD_ARB_STATS_EN
   task automatic test_stats();
      int pops = 0;
      do_reset();
      fill(200);
      req = 4'b1001;
      for (int c = 0; c < 100; c++) begin
         observe();
         vectors++;
         if (starve_flag !== '0 || pop_count !== 16'(pops)) begin
            miscompares++;
            $display("FAIL stats c=%0d: got starve=%b pop_count=%0d want 0/%0d",
                     c, starve_flag, pop_count, pops);
         end
         if (fifo_rd_en === 1'b1) pops++;
         advance();
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rd_rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 40) fill($urandom_range(1, 6));
         observe();
         vectors++;
         if ({gnt, busy, fifo_rd_en, out_valid} !== {exp_gnt, exp_busy, exp_rd_en, m_ov}) begin
            miscompares++;
            $display("FAIL rand_ctl c=%0d: got %b want %b", c,
                     {gnt, busy, fifo_rd_en, out_valid}, {exp_gnt, exp_busy, exp_rd_en, m_ov});
         end
         if (m_ov) begin
            vectors++;
            if ({out_id, out_data} !== {2'(m_oid), m_odata}) begin
               miscompares++;
               $display("FAIL rand_data c=%0d: got id=%0d data=%h want id=%0d data=%h",
                        c, out_id, out_data, m_oid, m_odata);
            end
         end
`ifdef FIFO_RD_ARB_STATS_EN
         vectors++;
         if (pop_count !== 16'(m_popcnt) || starve_flag !== m_starve) begin
            miscompares++;
            $display("FAIL rand_stats c=%0d: got pc=%0d sf=%b want pc=%0d sf=%b",
                     c, pop_count, starve_flag, m_popcnt, m_starve);
         end
`endif
         advance();
      end
      rd_rst = 1'b0;
   endtask

   initial begin
      rd_rst      = 1'b1;
      req         = '0;
      fifo_rempty = 1'b1;
      fifo_rdata  = '0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      test_reset();
      test_single_req();
      test_all_req();
      test_empty_mid_burst();
      test_req_drop();
      test_reset_mid_burst();
`ifdef FIFO_RD_ARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
